// File: rtl/sr_drv_pkg.sv
// rtl/sr_drv_pkg.sv - shared state type and sizing helper for the SR latch driver
package sr_drv_pkg;

  typedef enum logic [2:0] {
    INIT  = 3'd0,
    IDLE  = 3'd1,
    SCAN  = 3'd2,
    PULSE = 3'd3,
    GAP   = 3'd4,
    DONE  = 3'd5
  } drv_state_e;

  // Counter must hold the longer of the pulse and gap lengths.
  function automatic int cnt_w(input int pulse_cyc, input int gap_cyc);
    int m;
    m = (pulse_cyc > gap_cyc) ? pulse_cyc : gap_cyc;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sr_prio_enc.sv
// rtl/sr_prio_enc.sv - lowest-set-bit priority encoder
module sr_prio_enc #(
  parameter int N     = 8,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     vec,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    any = |vec;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/sr_latch_driver.sv
// rtl/sr_latch_driver.sv - drives one-at-a-time S/R pulses to bring an SR bank to a target word
module sr_latch_driver
  import sr_drv_pkg::*;
#(
  parameter int N         = 8,
  parameter int PULSE_CYC = 4,
  parameter int GAP_CYC   = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [N-1:0] req_data,
  output logic [N-1:0] s_out,
  output logic [N-1:0] r_out,
  input  logic [N-1:0] q_fb,
  output logic [N-1:0] shadow,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [N-1:0] err_mask
);

  localparam int CNT_W = cnt_w(PULSE_CYC, GAP_CYC);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYC - 1);

  drv_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [N-1:0]     target_q, target_d;
  logic [N-1:0]     pending_q, pending_d;
  logic [N-1:0]     shadow_q, shadow_d;
  logic [N-1:0]     err_mask_q, err_mask_d;
  logic [N-1:0]     s_q, s_d;
  logic [N-1:0]     r_q, r_d;
  logic             err_q, err_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             init_gap_q, init_gap_d;

  logic [IDX_W-1:0] enc_idx;
  logic             enc_any;

  sr_prio_enc #(.N(N), .IDX_W(IDX_W)) u_enc (
    .vec (pending_q),
    .idx (enc_idx),
    .any (enc_any)
  );

  // Next-state and registered-output logic; pulses are only ever held, never combined.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    target_d   = target_q;
    pending_d  = pending_q;
    shadow_d   = shadow_q;
    err_mask_d = err_mask_q;
    init_gap_d = init_gap_q;
    s_d        = '0;
    r_d        = '0;
    done_d     = 1'b0;
    ready_d    = 1'b0;
    busy_d     = 1'b1;

    case (state_q)
      INIT: begin
        if (!init_gap_q) begin
          // r_q is still zero only in the first cycle after reset.
          if (r_q == '0) begin
            r_d   = '1;
            cnt_d = PULSE_LAST;
          end else if (cnt_q == '0) begin
            init_gap_d = 1'b1;
            cnt_d      = GAP_LAST;
          end else begin
            r_d   = '1;
            cnt_d = cnt_q - 1'b1;
          end
        end else if (cnt_q == '0) begin
          init_gap_d = 1'b0;
          state_d    = IDLE;
          ready_d    = 1'b1;
          busy_d     = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      IDLE: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
        if (req_valid && ready_q) begin
          target_d   = req_data;
          pending_d  = req_data ^ shadow_q;
          err_mask_d = '0;
          state_d    = SCAN;
          ready_d    = 1'b0;
          busy_d     = 1'b1;
        end
      end

      SCAN: begin
        if (!enc_any) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          idx_d          = enc_idx;
          cnt_d          = PULSE_LAST;
          state_d        = PULSE;
          s_d[enc_idx]   = target_q[enc_idx];
          r_d[enc_idx]   = ~target_q[enc_idx];
        end
      end

      PULSE: begin
        if (cnt_q == '0) begin
          cnt_d   = GAP_LAST;
          state_d = GAP;
        end else begin
          cnt_d        = cnt_q - 1'b1;
          s_d[idx_q]   = target_q[idx_q];
          r_d[idx_q]   = ~target_q[idx_q];
        end
      end

      GAP: begin
        if (cnt_q == '0) begin
          err_mask_d[idx_q] = err_mask_q[idx_q] | (q_fb[idx_q] != target_q[idx_q]);
          shadow_d[idx_q]   = target_q[idx_q];
          pending_d[idx_q]  = 1'b0;
          state_d           = SCAN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end

      default: state_d = INIT;
    endcase

    err_d = |err_mask_d;
  end

  // State and datapath registers; reset drops the pulse outputs immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= INIT;
      cnt_q      <= '0;
      idx_q      <= '0;
      target_q   <= '0;
      pending_q  <= '0;
      shadow_q   <= '0;
      err_mask_q <= '0;
      err_q      <= 1'b0;
      s_q        <= '0;
      r_q        <= '0;
      done_q     <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b1;
      init_gap_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      target_q   <= target_d;
      pending_q  <= pending_d;
      shadow_q   <= shadow_d;
      err_mask_q <= err_mask_d;
      err_q      <= err_d;
      s_q        <= s_d;
      r_q        <= r_d;
      done_q     <= done_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      init_gap_q <= init_gap_d;
    end
  end

  assign s_out     = s_q;
  assign r_out     = r_q;
  assign shadow    = shadow_q;
  assign err_mask  = err_mask_q;
  assign err       = err_q;
  assign done      = done_q;
  assign req_ready = ready_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_sr_latch_driver.sv
// tb/tb_sr_latch_driver.sv - scoreboard bench for the SR latch driver
module tb_sr_latch_driver;

  localparam int N  = 8;
  localparam int PW = 4;
  localparam int GW = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [N-1:0] req_data = '0;
  logic [N-1:0] s_out, r_out, q_fb, shadow, err_mask;
  logic         busy, done, err;

  always #5 clk = ~clk;

  sr_latch_driver #(.N(N), .PULSE_CYC(PW), .GAP_CYC(GW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .s_out     (s_out),
    .r_out     (r_out),
    .q_fb      (q_fb),
    .shadow    (shadow),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .err_mask  (err_mask)
  );

  int checks = 0;
  int passed = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Physical SR bank: set pulse drives Q high, reset pulse drives it low; stuck bits read 0.
  logic [N-1:0] bank = '0;
  logic [N-1:0] stuck = '0;
  always @(posedge clk) bank <= (bank | s_out) & ~r_out;
  assign q_fb = bank & ~stuck;

  typedef struct { int ch; bit set; } pulse_t;
  typedef struct { logic [N-1:0] shadow; logic [N-1:0] emask; int acc; int lat; } done_t;

  pulse_t       pq[$];
  done_t        dq[$];
  logic [N-1:0] sh_model = '0;
  bit           in_init = 1'b1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic monitor_loop();
    logic [N-1:0] sr;
    logic [N-1:0] prev_sr;
    int           width;
    int           ch;
    bit           chk_ready;
    pulse_t       p;
    done_t        d;
    prev_sr   = '0;
    width     = 0;
    chk_ready = 1'b0;
    forever begin
      @(negedge clk);
      sr = s_out | r_out;
      check("s_r_exclusive", 32'(s_out & r_out), 32'd0);
      if (in_init) begin
        prev_sr   = '0;
        width     = 0;
        chk_ready = 1'b0;
      end else begin
        check("single_channel", 32'($onehot0(sr)), 32'd1);
        if (chk_ready) begin
          check("ready_after_done", 32'({busy, req_ready, done}), 32'b010);
          chk_ready = 1'b0;
        end
        if (sr != '0 && prev_sr == '0) begin
          check("pulse_expected", 32'(pq.size() != 0), 32'd1);
          if (pq.size() != 0) begin
            p  = pq.pop_front();
            ch = 0;
            for (int i = N - 1; i >= 0; i--) if (sr[i]) ch = i;
            check("pulse_channel", 32'(ch), 32'(p.ch));
            check("pulse_polarity", 32'(|s_out), 32'(p.set));
          end
          width = 1;
        end else if (sr != '0) begin
          check("pulse_stable", 32'(sr), 32'(prev_sr));
          width++;
        end else if (prev_sr != '0) begin
          check("pulse_width", 32'(width), 32'(PW));
        end
        if (done) begin
          check("done_expected", 32'(dq.size() != 0), 32'd1);
          if (dq.size() != 0) begin
            d = dq.pop_front();
            check("done_shadow", 32'(shadow), 32'(d.shadow));
            check("done_err_mask", 32'(err_mask), 32'(d.emask));
            check("done_err", 32'(err), 32'(|d.emask));
            check("done_latency", 32'(cyc - d.acc), 32'(d.lat));
            check("pulses_drained", 32'(pq.size()), 32'd0);
          end
          chk_ready = 1'b1;
        end
      end
      prev_sr = sr;
    end
  endtask

  task automatic do_reset();
    in_init = 1'b1;
    reset   = 1'b1;
    #1;
    check("rst_s_out", 32'(s_out), 32'd0);
    check("rst_r_out", 32'(r_out), 32'd0);
    check("rst_shadow", 32'(shadow), 32'd0);
    check("rst_err_mask", 32'(err_mask), 32'd0);
    check("rst_flags", 32'({req_ready, busy, done}), 32'b010);
    pq.delete();
    dq.delete();
    sh_model = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < PW + GW + 1; i++) begin
      @(negedge clk);
      check("init_r_out", 32'(r_out), (i < PW) ? 32'hFF : 32'h0);
      check("init_s_out", 32'(s_out), 32'd0);
      check("init_ready", 32'(req_ready), (i >= PW + GW) ? 32'd1 : 32'd0);
    end
    check("init_shadow", 32'(shadow), 32'd0);
    in_init = 1'b0;
  endtask

  // Reference: every channel that differs from the last commanded word is pulsed, lowest first.
  task automatic issue(input logic [N-1:0] tgt);
    logic [N-1:0] changed;
    int           k;
    int           n;
    n = 0;
    while (!req_ready && n < 300) begin
      req_valid = 1'($urandom_range(0, 1));
      req_data  = N'($urandom);
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      check("ready_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    changed = tgt ^ sh_model;
    k = 0;
    for (int i = 0; i < N; i++) begin
      if (changed[i]) begin
        pq.push_back('{ch: i, set: tgt[i]});
        k++;
      end
    end
    dq.push_back('{shadow: tgt, emask: changed & tgt & stuck, acc: cyc, lat: 2 + k * (1 + PW + GW)});
    sh_model  = tgt;
    req_valid = 1'b1;
    req_data  = tgt;
    @(negedge clk);
    req_valid = 1'b0;
    req_data  = N'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (dq.size() != 0 && n < 300) begin
      req_valid = 1'($urandom_range(0, 1));
      req_data  = N'($urandom);
      @(negedge clk);
      n++;
    end
    req_valid = 1'b0;
    check("done_timeout", 32'(dq.size()), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    int n;
    fork
      monitor_loop();
    join_none
    #2;
    do_reset();

    issue(8'h05); wait_idle();
    issue(8'h84); wait_idle();
    issue(8'h84); wait_idle();
    stuck = 8'h08;
    issue(8'h08); wait_idle();
    stuck = '0;
    issue(8'h08); wait_idle();

    for (int t = 0; t < 12; t++) begin
      stuck = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      issue(N'($urandom));
      wait_idle();
    end
    stuck = '0;

    issue(~sh_model);
    n = 0;
    while ((s_out | r_out) == '0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("mid_pulse_active", 32'(|(s_out | r_out)), 32'd1);
    do_reset();

    issue(8'h5A); wait_idle();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
